// File: rtl/decode_arb_pkg.sv
// Shared types and helpers for the round-robin decode arbiter.
// The round-robin scan lives here so that every user applies the same fairness rule.
package decode_arb_pkg;

  localparam int DEF_NREQ = 4;
  localparam int DEF_AW   = 5;
  localparam int DEF_HOLD = 4;

  // The scan is sized for the largest supported requester count (8).
  localparam int RR_MAX = 8;
  localparam int RR_IW  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic             found;
    logic [RR_IW-1:0] idx;
  } rr_pick_t;

  // Returns the first set request at or above ptr, wrapping modulo n.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                       input logic [RR_IW-1:0]  ptr,
                                       input int unsigned       n = DEF_NREQ);
    rr_pick_t    res;
    int unsigned j;
    res = '0;
    for (int unsigned k = 0; k < RR_MAX; k++) begin
      j = (32'(ptr) + k) % n;
      if (!res.found && (k < n) && req[j[RR_IW-1:0]]) begin
        res.found = 1'b1;
        res.idx   = j[RR_IW-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/decoder5to32.sv
// Purely combinational binary-to-one-hot decoder (AW inputs, 2**AW outputs).
module decoder5to32
  import decode_arb_pkg::*;
#(
  parameter int AW = DEF_AW
) (
  input  logic [AW-1:0]      addr,
  output logic [2**AW-1:0]   sel
);

  // NOTE: assigning a default before the indexed write keeps every bit driven
  // on every path, so no latch is inferred.
  always_comb begin
    sel       = '0;
    sel[addr] = 1'b1;
  end

endmodule

// File: rtl/decode_arbiter.sv
// Round-robin arbiter sharing one address decoder: winner's address is latched,
// decoded and driven for HOLD cycles, followed by a one-cycle all-zero gap.
module decode_arbiter
  import decode_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int AW   = DEF_AW,
  parameter int HOLD = DEF_HOLD
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*AW-1:0]      addr,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic [2**AW-1:0]        sel,
  output logic                    sel_valid,
  output logic                    busy
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int SW = 2**AW;

  arb_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [IW-1:0] gnt_id_q, gnt_id_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          sel_valid_q, sel_valid_d;
  logic          busy_q, busy_d;

  rr_pick_t      pick;
  logic [IW-1:0] win;
  logic [SW-1:0] dec_sel;

  // Decoding the captured-address next value lets the select register load
  // together with the grant, giving single-cycle request-to-select latency.
  decoder5to32 #(.AW(AW)) u_dec (
    .addr (addr_d),
    .sel  (dec_sel)
  );

  always_comb begin
    pick     = rr_pick(RR_MAX'(req), RR_IW'(ptr_q), NREQ);
    win      = IW'(pick.idx);

    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    addr_d   = addr_q;
    gnt_id_d = gnt_id_q;
    gnt_d    = '0;

    unique case (state_q)
      IDLE, GAP: begin
        if (pick.found) begin
          state_d       = DRIVE;
          cnt_d         = CW'(HOLD - 1);
          ptr_d         = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
          addr_d        = addr[int'(win)*AW +: AW];
          gnt_id_d      = win;
          gnt_d[win]    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      DRIVE: begin
        if (cnt_q == '0) state_d = GAP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    sel_valid_d = (state_d == DRIVE);
    busy_d      = (state_d != IDLE);
    sel_d       = sel_valid_d ? dec_sel : '0;
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      addr_q      <= '0;
      gnt_id_q    <= '0;
      gnt_q       <= '0;
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      addr_q      <= addr_d;
      gnt_id_q    <= gnt_id_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign sel       = sel_q;
  assign sel_valid = sel_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_decode_arbiter.sv
// Directed self-checking bench for decode_arbiter: reset, single grant, round-robin,
// wrap, late inputs, async reset mid-window, and a HOLD=1 instance.
module tb_decode_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, req_h1;
  logic [19:0] addr, addr_h1;
  logic [3:0]  gnt, gnt_h1;
  logic [1:0]  gnt_id, gnt_id_h1;
  logic [31:0] sel, sel_h1;
  logic        sel_valid, sel_valid_h1;
  logic        busy, busy_h1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0] rr_addr [4];

  always #5 clk = ~clk;

  decode_arbiter #(.NREQ(4), .AW(5), .HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .addr      (addr),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .sel       (sel),
    .sel_valid (sel_valid),
    .busy      (busy)
  );

  decode_arbiter #(.NREQ(4), .AW(5), .HOLD(1)) dut_h1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_h1),
    .addr      (addr_h1),
    .gnt       (gnt_h1),
    .gnt_id    (gnt_id_h1),
    .sel       (sel_h1),
    .sel_valid (sel_valid_h1),
    .busy      (busy_h1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; req_h1 = '0; addr = '0; addr_h1 = '0;
    tick();
    req = 4'b1111; tick();
    req = 4'b0000; tick();
    req = 4'b1010; tick();
    n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b exp 0000", gnt); end
    n_tests++; if (gnt_id !== 2'd0) begin n_fail++; $display("FAIL reset_gnt_id: got %0d exp 0", gnt_id); end
    n_tests++; if (sel !== 32'h0) begin n_fail++; $display("FAIL reset_sel: got %h exp 0", sel); end
    n_tests++; if (sel_valid !== 1'b0) begin n_fail++; $display("FAIL reset_sel_valid: got %b exp 0", sel_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
    req = '0;
    rst_n = 1'b1;
    tick(); tick();
    n_tests++; if (busy !== 1'b0 || sel_valid !== 1'b0 || gnt !== 4'b0) begin
      n_fail++; $display("FAIL reset_idle: busy=%b sel_valid=%b gnt=%b exp 0/0/0000", busy, sel_valid, gnt);
    end
  endtask

  // ptr starts at 0: expect grants 0,1,2,3,0 every HOLD+1 = 5 cycles.
  task automatic test_round_robin();
    int id;
    rr_addr[0] = 5'd3; rr_addr[1] = 5'd9; rr_addr[2] = 5'd22; rr_addr[3] = 5'd31;
    for (int i = 0; i < 4; i++) addr[i*5 +: 5] = rr_addr[i];
    req = 4'b1111;
    tick();
    for (int g = 0; g < 5; g++) begin
      id = g % 4;
      n_tests++; if (gnt !== (4'b0001 << id) || gnt_id !== 2'(id)) begin
        n_fail++; $display("FAIL rr_grant%0d: got gnt=%b id=%0d exp gnt=%b id=%0d", g, gnt, gnt_id, 4'b0001 << id, id);
      end
      n_tests++; if (sel !== (32'h1 << rr_addr[id]) || sel_valid !== 1'b1) begin
        n_fail++; $display("FAIL rr_sel%0d: got sel=%h v=%b exp sel=%h v=1", g, sel, sel_valid, 32'h1 << rr_addr[id]);
      end
      if (g == 4) req = '0;
      for (int c = 0; c < 3; c++) begin
        tick();
        n_tests++; if (sel !== (32'h1 << rr_addr[id]) || sel_valid !== 1'b1 || gnt !== 4'b0) begin
          n_fail++; $display("FAIL rr_hold%0d_%0d: got sel=%h v=%b gnt=%b exp sel=%h v=1 gnt=0000",
                             g, c, sel, sel_valid, gnt, 32'h1 << rr_addr[id]);
        end
      end
      tick();
      n_tests++; if (sel !== 32'h0 || sel_valid !== 1'b0 || busy !== 1'b1) begin
        n_fail++; $display("FAIL rr_gap%0d: got sel=%h v=%b busy=%b exp 0/0/1", g, sel, sel_valid, busy);
      end
      tick();
    end
    n_tests++; if (busy !== 1'b0 || gnt !== 4'b0) begin
      n_fail++; $display("FAIL rr_end_idle: got busy=%b gnt=%b exp 0/0000", busy, gnt);
    end
  endtask

  // ptr=1 here: grant 2 moves ptr to 3; then req=0011 wraps to 0 and ptr becomes 1.
  task automatic test_wrap();
    addr[2*5 +: 5] = 5'd11;
    req = 4'b0100;
    tick();
    n_tests++; if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
      n_fail++; $display("FAIL wrap_first: got gnt=%b id=%0d exp 0100/2", gnt, gnt_id);
    end
    req = '0;
    repeat (5) tick();
    addr[0 +: 5] = 5'd2; addr[5 +: 5] = 5'd6;
    req = 4'b0011;
    tick();
    n_tests++; if (gnt !== 4'b0001 || gnt_id !== 2'd0 || sel !== (32'h1 << 2)) begin
      n_fail++; $display("FAIL wrap_to_zero: got gnt=%b id=%0d sel=%h exp 0001/0/%h", gnt, gnt_id, sel, 32'h1 << 2);
    end
    repeat (4) tick();
    n_tests++; if (sel_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL wrap_gap: got v=%b busy=%b exp 0/1", sel_valid, busy);
    end
    tick();
    n_tests++; if (gnt !== 4'b0010 || gnt_id !== 2'd1 || sel !== (32'h1 << 6)) begin
      n_fail++; $display("FAIL wrap_ptr_next: got gnt=%b id=%0d sel=%h exp 0010/1/%h", gnt, gnt_id, sel, 32'h1 << 6);
    end
    req = '0;
    repeat (5) tick();
  endtask

  // ptr=2: request 0 wins; mid-window inputs must not disturb sel.
  task automatic test_late_input();
    addr[0 +: 5] = 5'd5;
    req = 4'b0001;
    tick();
    n_tests++; if (gnt !== 4'b0001 || sel !== (32'h1 << 5)) begin
      n_fail++; $display("FAIL late_grant: got gnt=%b sel=%h exp 0001/%h", gnt, sel, 32'h1 << 5);
    end
    req = '0;
    tick();
    req = 4'b0100; addr[0 +: 5] = 5'd12; addr[2*5 +: 5] = 5'd7;
    for (int c = 0; c < 3; c++) begin
      n_tests++; if (sel !== (32'h1 << 5) || gnt !== 4'b0) begin
        n_fail++; $display("FAIL late_stable%0d: got sel=%h gnt=%b exp %h/0000", c, sel, gnt, 32'h1 << 5);
      end
      tick();
    end
    n_tests++; if (sel !== 32'h0 || gnt !== 4'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL late_gap: got sel=%h gnt=%b busy=%b exp 0/0000/1", sel, gnt, busy);
    end
    tick();
    n_tests++; if (gnt !== 4'b0100 || gnt_id !== 2'd2 || sel !== (32'h1 << 7)) begin
      n_fail++; $display("FAIL late_req2: got gnt=%b id=%0d sel=%h exp 0100/2/%h", gnt, gnt_id, sel, 32'h1 << 7);
    end
    req = '0;
    repeat (5) tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL late_idle: got busy=%b exp 0", busy); end
  endtask

  // ptr=3: request 1 wins; reset mid-window must clear outputs without an edge.
  task automatic test_async_reset();
    addr[5 +: 5] = 5'd20;
    req = 4'b0010;
    tick();
    n_tests++; if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
      n_fail++; $display("FAIL arst_grant: got gnt=%b id=%0d exp 0010/1", gnt, gnt_id);
    end
    req = '0;
    tick();
    n_tests++; if (sel !== (32'h1 << 20) || sel_valid !== 1'b1) begin
      n_fail++; $display("FAIL arst_pre: got sel=%h v=%b exp %h/1", sel, sel_valid, 32'h1 << 20);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (sel !== 32'h0 || sel_valid !== 1'b0 || busy !== 1'b0 || gnt_id !== 2'd0) begin
      n_fail++; $display("FAIL arst_clear: got sel=%h v=%b busy=%b id=%0d exp 0/0/0/0", sel, sel_valid, busy, gnt_id);
    end
    tick(); tick();
    rst_n = 1'b1;
    req = 4'b1010;
    tick();
    n_tests++; if (gnt !== 4'b0010 || gnt_id !== 2'd1 || sel !== (32'h1 << 20)) begin
      n_fail++; $display("FAIL arst_ptr0: got gnt=%b id=%0d sel=%h exp 0010/1/%h", gnt, gnt_id, sel, 32'h1 << 20);
    end
    req = '0;
    repeat (5) tick();
  endtask

  // HOLD=1: gnt and sel_valid coincide; held request gives a grant every 2 cycles.
  task automatic test_hold_one();
    addr_h1[0 +: 5] = 5'd9;
    req_h1 = 4'b0001;
    tick();
    n_tests++; if (gnt_h1 !== 4'b0001 || sel_valid_h1 !== 1'b1 || sel_h1 !== (32'h1 << 9)) begin
      n_fail++; $display("FAIL h1_grant: got gnt=%b v=%b sel=%h exp 0001/1/%h", gnt_h1, sel_valid_h1, sel_h1, 32'h1 << 9);
    end
    tick();
    n_tests++; if (sel_valid_h1 !== 1'b0 || busy_h1 !== 1'b1 || gnt_h1 !== 4'b0 || sel_h1 !== 32'h0) begin
      n_fail++; $display("FAIL h1_gap: got v=%b busy=%b gnt=%b sel=%h exp 0/1/0000/0", sel_valid_h1, busy_h1, gnt_h1, sel_h1);
    end
    tick();
    n_tests++; if (gnt_h1 !== 4'b0001 || sel_valid_h1 !== 1'b1) begin
      n_fail++; $display("FAIL h1_back_to_back: got gnt=%b v=%b exp 0001/1", gnt_h1, sel_valid_h1);
    end
    req_h1 = '0;
    tick(); tick();
    n_tests++; if (busy_h1 !== 1'b0) begin n_fail++; $display("FAIL h1_idle: got busy=%b exp 0", busy_h1); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_wrap();
    test_late_input();
    test_async_reset();
    test_hold_one();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
